riscv_wb_arbiter: RTL and testbench
===================================

RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, the consecutive pipeline-priority cycles tolerated while an MDU result waits (legal 1..15).
REQ-002 The block SHALL have port i_riscv_mw_clk  input  1  clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_riscv_mw_rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port i_riscv_wbarb_pipe_regw  input  1  write-back stage register-write enable.
REQ-005 The block SHALL have port i_riscv_wbarb_pipe_rdaddr  input  5  write-back stage destination register.
REQ-006 The block SHALL have port i_riscv_wbarb_pipe_data  input  64  write-back stage result.
REQ-007 The block SHALL have port i_riscv_wbarb_mdu_valid  input  1  long-latency unit result valid.
REQ-008 The block SHALL have port i_riscv_wbarb_mdu_rdaddr  input  5  long-latency unit destination register.
REQ-009 The block SHALL have port i_riscv_wbarb_mdu_data  input  64  long-latency unit result.
REQ-010 The block SHALL have port o_riscv_wbarb_mdu_ready  output  1  result buffer can accept.
REQ-011 The block SHALL have port o_riscv_wbarb_mw_stall  output  1  hold request to the memory/write-back pipeline register (1 = hold).
REQ-012 The block SHALL have port o_riscv_wbarb_rf_we  output  1  register-file write enable.
REQ-013 The block SHALL have port o_riscv_wbarb_rf_addr  output  5  register-file write address.
REQ-014 The block SHALL have port o_riscv_wbarb_rf_data  output  64  register-file write data.
REQ-015 The block SHALL have port o_riscv_wbarb_fifo_count  output  2  buffered MDU results (0..2).

Function
REQ-016 The MDU result buffer SHALL be a 2-entry FIFO; push on mdu_valid && mdu_ready; mdu_ready = (count != 2), combinational.
REQ-017 pipe_req SHALL be pipe_regw && (pipe_rdaddr != 0); rd = x0 with regw = 1 SHALL never write and SHALL never stall.
REQ-018 grant_mdu SHALL be (count != 0) && (!pipe_req || count == 2 || starve_force), combinational.
REQ-019 o_riscv_wbarb_mw_stall SHALL be pipe_req && grant_mdu, combinational, same cycle; the stalled pipeline request is re-presented next cycle.
REQ-020 On each edge: grant_mdu -> rf_we=1, rf_addr/rf_data = FIFO head, pop; else pipe_req -> rf_we=1 with pipeline addr/data; else rf_we=0, rf_addr=0, rf_data=0 (1-cycle latency, registered).
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push data SHALL never bypass to the RF port in the same cycle.
REQ-022 MDU results SHALL retire in arrival order.
REQ-023 o_riscv_wbarb_fifo_count SHALL reflect the registered count.

Reset
REQ-024 While i_riscv_mw_rst = 1: count=0, FIFO pointers=0, starvation counter=0, rf_we=0, rf_addr=0, rf_data=0; hence mdu_ready=1, mw_stall=0.
REQ-025 Reset asserted mid-operation SHALL discard buffered MDU results.

Configuration
REQ-026 Macro RISCV_WBARB_STARVE_EN defined: a 4-bit saturating counter increments when count != 0 && pipe_req && !grant_mdu, clears on grant_mdu or count == 0; starve_force = (counter == STARVE_LIMIT).
REQ-027 Macro RISCV_WBARB_STARVE_EN undefined: no counter; starve_force = 0; MDU granted only on idle pipeline slots or full FIFO.

Verification
REQ-028 Reset, then idle inputs -> rf_we=0, mw_stall=0, mdu_ready=1, fifo_count=0.
REQ-029 pipe_regw=1, rdaddr=5, data=0xA5 with FIFO empty -> next edge rf_we=1, rf_addr=5, rf_data=0xA5, mw_stall=0 throughout.
REQ-030 pipe_regw=1, rdaddr=0 with one MDU entry (rd=7, data=0x3) -> no stall; next edge writes x7=0x3.
REQ-031 Two MDU pushes (rd=1, rd=2) during continuous pipe_req -> count=2, mdu_ready=0, mw_stall=1; x1 retires, then x2 retires only if count returns to 2 or starvation fires; pipeline write resumes after stall drops.
REQ-032 With RISCV_WBARB_STARVE_EN, STARVE_LIMIT=4, one MDU entry plus continuous pipe_req -> 4 pipeline writes, then mw_stall=1 for 1 cycle and the MDU write; without macro, the MDU entry waits until pipe_req drops.
REQ-033 Assert rst while count=2 -> count=0, no MDU write after reset release.

Source files
------------

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: shares the register-file write port between the
// write-back pipeline stage and a 2-entry buffer of long-latency (MDU)
// results. The pipeline has priority unless the buffer is full or, when
// RISCV_WBARB_STARVE_EN is defined, the oldest MDU result has waited
// STARVE_LIMIT pipeline-priority cycles. Winning the port over a live
// pipeline request stalls the memory/write-back register for one cycle.
module riscv_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_riscv_mw_clk,
    input  logic        i_riscv_mw_rst,
    input  logic        i_riscv_wbarb_pipe_regw,
    input  logic [4:0]  i_riscv_wbarb_pipe_rdaddr,
    input  logic [63:0] i_riscv_wbarb_pipe_data,
    input  logic        i_riscv_wbarb_mdu_valid,
    input  logic [4:0]  i_riscv_wbarb_mdu_rdaddr,
    input  logic [63:0] i_riscv_wbarb_mdu_data,
    output logic        o_riscv_wbarb_mdu_ready,
    output logic        o_riscv_wbarb_mw_stall,
    output logic        o_riscv_wbarb_rf_we,
    output logic [4:0]  o_riscv_wbarb_rf_addr,
    output logic [63:0] o_riscv_wbarb_rf_data,
    output logic [1:0]  o_riscv_wbarb_fifo_count
);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
        $error("riscv_wb_arbiter: STARVE_LIMIT must be within 1..15");
    end

    logic [4:0]  r_fifo_addr [2];
    logic [63:0] r_fifo_data [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic        r_rf_we;
    logic [4:0]  r_rf_addr;
    logic [63:0] r_rf_data;

    logic        w_pipe_req;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_grant_mdu;
    logic        w_starve_force;

    assign w_pipe_req   = i_riscv_wbarb_pipe_regw && (i_riscv_wbarb_pipe_rdaddr != 5'd0);
    assign w_fifo_full  = (r_count == 2'd2);
    assign w_fifo_empty = (r_count == 2'd0);
    assign w_push       = i_riscv_wbarb_mdu_valid && !w_fifo_full;
    assign w_grant_mdu  = !w_fifo_empty && (!w_pipe_req || w_fifo_full || w_starve_force);
    assign w_pop        = w_grant_mdu;

`ifdef RISCV_WBARB_STARVE_EN
    logic [3:0] r_starve_cnt;

    // Count cycles the buffered head loses to the pipeline; saturates at 15.
    always_ff @(posedge i_riscv_mw_clk or posedge i_riscv_mw_rst) begin
        if (i_riscv_mw_rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_mdu || w_fifo_empty) begin
            r_starve_cnt <= '0;
        end else if (w_pipe_req && (r_starve_cnt != 4'd15)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign w_starve_force = (r_starve_cnt == 4'(STARVE_LIMIT));
`else
    assign w_starve_force = 1'b0;
`endif

    // Buffer storage: written at the tail on push, no reset needed.
    always_ff @(posedge i_riscv_mw_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= i_riscv_wbarb_mdu_rdaddr;
            r_fifo_data[r_wr_ptr] <= i_riscv_wbarb_mdu_data;
        end
    end

    // Buffer pointers and occupancy; push+pop together keeps the count.
    always_ff @(posedge i_riscv_mw_clk or posedge i_riscv_mw_rst) begin
        if (i_riscv_mw_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered register-file write port: MDU head, else pipeline, else idle zeros.
    always_ff @(posedge i_riscv_mw_clk or posedge i_riscv_mw_rst) begin
        if (i_riscv_mw_rst) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else if (w_grant_mdu) begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= r_fifo_addr[r_rd_ptr];
            r_rf_data <= r_fifo_data[r_rd_ptr];
        end else if (w_pipe_req) begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= i_riscv_wbarb_pipe_rdaddr;
            r_rf_data <= i_riscv_wbarb_pipe_data;
        end else begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end
    end

    assign o_riscv_wbarb_mdu_ready  = !w_fifo_full;
    assign o_riscv_wbarb_mw_stall   = w_pipe_req && w_grant_mdu;
    assign o_riscv_wbarb_rf_we      = r_rf_we;
    assign o_riscv_wbarb_rf_addr    = r_rf_addr;
    assign o_riscv_wbarb_rf_data    = r_rf_data;
    assign o_riscv_wbarb_fifo_count = r_count;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: directed scenarios followed by random traffic,
// checked against a queue-based model of the arbitration rules. Expected RF
// writes go into a scoreboard queue drained by an independent monitor.
// Honours RISCV_WBARB_STARVE_EN the same way as the design.
module tb_riscv_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_regw;
    logic [4:0]  pipe_rdaddr;
    logic [63:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rdaddr;
    logic [63:0] mdu_data;
    logic        mdu_ready;
    logic        mw_stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [63:0] rf_data;
    logic [1:0]  fifo_count;

    riscv_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_riscv_mw_clk            (clk),
        .i_riscv_mw_rst            (rst),
        .i_riscv_wbarb_pipe_regw   (pipe_regw),
        .i_riscv_wbarb_pipe_rdaddr (pipe_rdaddr),
        .i_riscv_wbarb_pipe_data   (pipe_data),
        .i_riscv_wbarb_mdu_valid   (mdu_valid),
        .i_riscv_wbarb_mdu_rdaddr  (mdu_rdaddr),
        .i_riscv_wbarb_mdu_data    (mdu_data),
        .o_riscv_wbarb_mdu_ready   (mdu_ready),
        .o_riscv_wbarb_mw_stall    (mw_stall),
        .o_riscv_wbarb_rf_we       (rf_we),
        .o_riscv_wbarb_rf_addr     (rf_addr),
        .o_riscv_wbarb_rf_data     (rf_data),
        .o_riscv_wbarb_fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;

    wr_t mq[$];     // model of buffered MDU results, oldest first
    wr_t expq[$];   // scoreboard: expected RF writes in order
    int  starve;
    int  checks = 0;
    int  errors = 0;
    bit  last_stall;
    int  mdu_writes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every RF write against the scoreboard head.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=addr %0d data %0h required=no write", rf_addr, rf_data);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("rf_addr", 64'(rf_addr), 64'(e.a));
                chk("rf_data", rf_data, e.d);
            end
        end else begin
            chk("idle_addr", 64'(rf_addr), 64'd0);
            chk("idle_data", rf_data, 64'd0);
        end
    end

    // Called at posedge+1: drive one cycle, check combinational outputs
    // against the model, advance the model, return at next posedge+1.
    task automatic step(input logic regw, input logic [4:0] rd, input logic [63:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [63:0] md);
        bit pr, sf, g;
        int n;
        pipe_regw   = regw;
        pipe_rdaddr = rd;
        pipe_data   = pd;
        mdu_valid   = mv;
        mdu_rdaddr  = mrd;
        mdu_data    = md;
        #2;
        n  = mq.size();
        pr = regw && (rd != 5'd0);
`ifdef RISCV_WBARB_STARVE_EN
        sf = (starve == LIMIT);
`else
        sf = 1'b0;
`endif
        g  = (n != 0) && (!pr || n == 2 || sf);
        chk("mdu_ready", 64'(mdu_ready), 64'(n != 2));
        chk("mw_stall", 64'(mw_stall), 64'(pr && g));
        chk("fifo_count", 64'(fifo_count), 64'(n));
        last_stall = pr && g;
        if (g) begin
            expq.push_back(mq.pop_front());
            mdu_writes++;
        end else if (pr) begin
            expq.push_back('{a: rd, d: pd});
        end
        if (mv && n != 2) mq.push_back('{a: mrd, d: md});
        if (g || n == 0) starve = 0;
        else if (pr && starve < 15) starve++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pipe_regw = 1'b0; pipe_rdaddr = '0; pipe_data = '0;
        mdu_valid = 1'b0; mdu_rdaddr = '0; mdu_data = '0;
        mq.delete();
        expq.delete();
        starve = 0;
        #2;
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(mdu_ready), 64'd1);
        chk("rst_stall", 64'(mw_stall), 64'd0);
        chk("rst_we", 64'(rf_we), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic        r_regw;
        logic [4:0]  r_rd;
        logic [63:0] r_pd;
        int          w0;
        rst = 1'b1;
        pipe_regw = 1'b0; pipe_rdaddr = '0; pipe_data = '0;
        mdu_valid = 1'b0; mdu_rdaddr = '0; mdu_data = '0;
        starve = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // idle
        repeat (2) step(0, 0, 0, 0, 0, 0);
        // single pipeline write x5 = A5
        step(1, 5, 64'hA5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // one MDU entry, then a pipeline x0 write: MDU wins with no stall
        step(0, 0, 0, 1, 7, 64'h3);
        step(1, 0, 64'hDEAD, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // two MDU pushes under continuous pipeline traffic
        step(1, 3, 64'h100, 1, 1, 64'h11);
        step(1, 4, 64'h101, 1, 2, 64'h22);
        for (int i = 0; i < 20; i++) step(1, 5'(8 + i), 64'(i), 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        // one MDU entry under continuous pipeline traffic: starvation path
        w0 = mdu_writes;
        step(1, 9, 64'h200, 1, 12, 64'h1234);
        for (int i = 0; i < 12; i++) step(1, 5'(10 + i), 64'(300 + i), 0, 0, 0);
`ifdef RISCV_WBARB_STARVE_EN
        chk("starve_retired", 64'(mdu_writes - w0), 64'd1);
`else
        chk("starve_waits", 64'(mdu_writes - w0), 64'd0);
`endif
        repeat (3) step(0, 0, 0, 0, 0, 0);
        // fill buffer, reset while full: nothing retires afterward
        step(1, 6, 64'h1, 1, 20, 64'hAA);
        step(1, 6, 64'h2, 1, 21, 64'hBB);
        chk("full_before_rst", 64'(fifo_count), 64'd2);
        do_reset();
        repeat (4) step(0, 0, 0, 0, 0, 0);

        // random traffic, pipeline biased busy; stalled requests are re-presented
        r_regw = 0; r_rd = 0; r_pd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                r_regw = ($urandom_range(0, 9) < 7);
                r_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                r_pd   = {$urandom, $urandom};
            end
            if (i == 1500) do_reset();
            step(r_regw, r_rd, r_pd, ($urandom_range(0, 3) == 0), 5'($urandom), {$urandom, $urandom});
        end
        repeat (4) step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
